dual_port_ram_be_clr: RTL and testbench

//  True dual-port block RAM (M20K) with per-byte write enables, configurable

---
 rtl/dual_port_ram_be_clr.sv | 142 ++++++++++++++
 tb/tb_dual_port_ram_be_clr.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_be_clr.sv
// True dual-port RAM with per-byte write enables, a pipelined read path with
// valid tracking, collision flagging and a post-reset zero-fill sequencer.
module dual_port_ram_be_clr #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [ADDR_WIDTH-1:0]           addr_a_i,
  input  logic [DATA_WIDTH-1:0]           di_a_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a_i,
  input  logic                            we_a_i,
  input  logic                            re_a_i,
  input  logic                            en_a_i,
  output logic [DATA_WIDTH-1:0]           do_a_o,
  output logic                            do_valid_a_o,
  input  logic [ADDR_WIDTH-1:0]           addr_b_i,
  input  logic [DATA_WIDTH-1:0]           di_b_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b_i,
  input  logic                            we_b_i,
  input  logic                            re_b_i,
  input  logic                            en_b_i,
  output logic [DATA_WIDTH-1:0]           do_b_o,
  output logic                            do_valid_b_o,
  output logic                            busy_o,
  output logic                            collision_o
);

  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    ready;
  logic                    wr_a, wr_b, rd_a, rd_b;
  logic [NBYTES-1:0]       bew_a, bew_b;
  logic [DATA_WIDTH-1:0]   merged_a, merged_b, wdata_a;
  logic                    coll_d, coll_q;

  logic [DATA_WIDTH-1:0]   data_a_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   data_b_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_a_q, vld_b_q;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NBYTES-1:0]     be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NBYTES; i++)
      if (be[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = S_READY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready  = (state_q == S_READY);
  assign busy_o = ~ready;

  // A write with no byte lanes enabled is treated as no write at all.
  assign bew_a = (ready && en_a_i && we_a_i) ? be_a_i : '0;
  assign bew_b = (ready && en_b_i && we_b_i) ? be_b_i : '0;
  assign wr_a  = |bew_a;
  assign wr_b  = |bew_b;
  assign rd_a  = ready && en_a_i && re_a_i;
  assign rd_b  = ready && en_b_i && re_b_i;

  // Write-first read data per port; A's write stacks on B's so that lanes
  // only B enabled still land when both ports hit the same word.
  assign merged_a = merge_lanes(mem[addr_a_i], di_a_i, bew_a);
  assign merged_b = merge_lanes(mem[addr_b_i], di_b_i, bew_b);
  assign wdata_a  = merge_lanes((wr_b && addr_b_i == addr_a_i) ? merged_b : mem[addr_a_i],
                                di_a_i, bew_a);

  always_ff @(posedge clk_i) begin
    if (!ready) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr_b) mem[addr_b_i] <= merged_b;
      if (wr_a) mem[addr_a_i] <= wdata_a;
    end
  end

  assign coll_d = ready && en_a_i && en_b_i && (addr_a_i == addr_b_i) && (wr_a || wr_b);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      coll_q  <= 1'b0;
      vld_a_q <= '0;
      vld_b_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_a_q[i] <= '0;
        data_b_q[i] <= '0;
      end
    end else begin
      coll_q     <= coll_d;
      vld_a_q[0] <= rd_a;
      vld_b_q[0] <= rd_b;
      if (rd_a) data_a_q[0] <= merged_a;
      if (rd_b) data_b_q[0] <= merged_b;
      // Later stages only advance on valid, so the output holds the last read.
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_a_q[i] <= vld_a_q[i-1];
        vld_b_q[i] <= vld_b_q[i-1];
        if (vld_a_q[i-1]) data_a_q[i] <= data_a_q[i-1];
        if (vld_b_q[i-1]) data_b_q[i] <= data_b_q[i-1];
      end
    end
  end

  assign do_a_o       = data_a_q[READ_LATENCY-1];
  assign do_b_o       = data_b_q[READ_LATENCY-1];
  assign do_valid_a_o = vld_a_q[READ_LATENCY-1];
  assign do_valid_b_o = vld_b_q[READ_LATENCY-1];
  assign collision_o  = coll_q;

endmodule

// File: tb/tb_dual_port_ram_be_clr.sv
// Directed bench: a latency-1 and a latency-3 instance share all inputs on a
// 16-word memory; expected values are hand-computed constants.
module tb_dual_port_ram_be_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr_a, addr_b;
  logic [31:0] di_a, di_b;
  logic [3:0]  be_a, be_b;
  logic        we_a, re_a, en_a, we_b, re_b, en_b;

  logic [31:0] do_a, do_b, do_a3, do_b3;
  logic        dv_a, dv_b, dv_a3, dv_b3;
  logic        busy, busy3, coll, coll3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dual_port_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                         .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .addr_a_i(addr_a), .di_a_i(di_a), .be_a_i(be_a), .we_a_i(we_a), .re_a_i(re_a), .en_a_i(en_a),
    .do_a_o(do_a), .do_valid_a_o(dv_a),
    .addr_b_i(addr_b), .di_b_i(di_b), .be_b_i(be_b), .we_b_i(we_b), .re_b_i(re_b), .en_b_i(en_b),
    .do_b_o(do_b), .do_valid_b_o(dv_b),
    .busy_o(busy), .collision_o(coll));

  dual_port_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                         .READ_LATENCY(3), .CLEAR_ON_RESET(1)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .addr_a_i(addr_a), .di_a_i(di_a), .be_a_i(be_a), .we_a_i(we_a), .re_a_i(re_a), .en_a_i(en_a),
    .do_a_o(do_a3), .do_valid_a_o(dv_a3),
    .addr_b_i(addr_b), .di_b_i(di_b), .be_b_i(be_b), .we_b_i(we_b), .re_b_i(re_b), .en_b_i(en_b),
    .do_b_o(do_b3), .do_valid_b_o(dv_b3),
    .busy_o(busy3), .collision_o(coll3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; re_a = 0; be_a = '0; addr_a = '0; di_a = '0;
    en_b = 0; we_b = 0; re_b = 0; be_b = '0; addr_b = '0; di_b = '0;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    en_a = 1; we_a = 1; addr_a = a; di_a = d; be_a = be;
    tick();
    idle();
  endtask

  task automatic rd_a(input string tag, input logic [3:0] a, input logic [31:0] exp);
    en_a = 1; re_a = 1; addr_a = a;
    tick();
    idle();
    check({tag, "_vld"}, {31'd0, dv_a}, 32'd1);
    check({tag, "_data"}, do_a, exp);
  endtask

  // Counts cycles until BUSY drops; while busy, hammers both ports with
  // requests that must be ignored and records any stray valid/collision.
  task automatic count_fill(input string tag);
    int n;
    logic stray;
    n = 0;
    stray = 1'b0;
    while (busy && n < 100) begin
      en_a = 1; we_a = 1; re_a = 1; be_a = 4'hF; addr_a = 4'd5; di_a = 32'hFFFF_FFFF;
      en_b = 1; we_b = 1; re_b = 1; be_b = 4'hF; addr_b = 4'd5; di_b = 32'hEEEE_EEEE;
      tick();
      n++;
      stray = stray | dv_a | dv_b | dv_a3 | dv_b3 | coll | coll3;
    end
    idle();
    check({tag, "_busy_cycles"}, n, 32'd16);
    check({tag, "_no_stray"}, {31'd0, stray}, 32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_do_a", do_a, 32'd0);
    check("rst_vld_b3", {31'd0, dv_b3}, 32'd0);
    check("rst_coll", {31'd0, coll}, 32'd0);
    rst = 1'b0;

    // Zero-fill then every word reads back as zero.
    count_fill("fill1");
    for (int i = 0; i < 16; i++) rd_a($sformatf("zero%0d", i), 4'(i), 32'd0);

    // Byte-lane merge across ports.
    wr_a(4'd5, 32'hAABB_CCDD, 4'b1111);
    en_b = 1; we_b = 1; addr_b = 4'd5; di_b = 32'h1122_3344; be_b = 4'b0101;
    tick();
    idle();
    rd_a("merge5", 4'd5, 32'hAA22_CC44);

    // Disabled port must not write.
    en_a = 0; we_a = 1; addr_a = 4'd5; di_a = 32'h0; be_a = 4'hF;
    tick();
    idle();
    rd_a("en_off", 4'd5, 32'hAA22_CC44);

    // Latency-3 streaming on port B; latency-1 instance seen alongside.
    for (int i = 0; i < 8; i++) wr_a(4'(i), 32'h100 + i, 4'hF);
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        en_b = 1; re_b = 1; addr_b = 4'(c);
      end else begin
        idle();
      end
      tick();
      check($sformatf("l3_vld%0d", c), {31'd0, dv_b3}, (c >= 2 && c <= 9) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 9) check($sformatf("l3_data%0d", c), do_b3, 32'h100 + c - 2);
      check($sformatf("l1_vld%0d", c), {31'd0, dv_b}, (c < 8) ? 32'd1 : 32'd0);
    end
    check("l3_hold", do_b3, 32'h107);

    // Both ports write the same word: collision once, port A wins.
    en_a = 1; we_a = 1; addr_a = 4'd9; di_a = 32'h1; be_a = 4'hF;
    en_b = 1; we_b = 1; addr_b = 4'd9; di_b = 32'h2; be_b = 4'hF;
    tick();
    idle();
    check("coll_pulse", {31'd0, coll}, 32'd1);
    tick();
    check("coll_clear", {31'd0, coll}, 32'd0);
    rd_a("coll9", 4'd9, 32'h1);

    // Two reads of one address: both valid, no collision.
    en_a = 1; re_a = 1; addr_a = 4'd9;
    en_b = 1; re_b = 1; addr_b = 4'd9;
    tick();
    idle();
    check("rr_coll", {31'd0, coll}, 32'd0);
    check("rr_a", do_a, 32'h1);
    check("rr_vld_b", {31'd0, dv_b}, 32'd1);
    check("rr_b", do_b, 32'h1);

    // Write with no byte enables against a read: no change, no collision.
    en_a = 1; we_a = 1; addr_a = 4'd9; di_a = 32'hFF; be_a = 4'h0;
    en_b = 1; re_b = 1; addr_b = 4'd9;
    tick();
    idle();
    check("be0_coll", {31'd0, coll}, 32'd0);
    rd_a("be0_keep", 4'd9, 32'h1);

    // Same-port write-first read returns merged word.
    wr_a(4'd3, 32'h1234_5678, 4'hF);
    en_a = 1; we_a = 1; re_a = 1; addr_a = 4'd3; di_a = 32'hDEAD_BEEF; be_a = 4'b0011;
    tick();
    idle();
    check("wf_vld", {31'd0, dv_a}, 32'd1);
    check("wf_data", do_a, 32'h1234_BEEF);
    tick();
    check("wf_pulse", {31'd0, dv_a}, 32'd0);
    check("wf_hold", do_a, 32'h1234_BEEF);

    // Reset with a latency-3 read in flight, then again mid-fill at count 7.
    en_b = 1; re_b = 1; addr_b = 4'd1;
    tick();
    idle();
    rst = 1'b1;
    #1;
    check("inflight_vld", {31'd0, dv_b3}, 32'd0);
    check("inflight_do", do_b3, 32'd0);
    tick();
    tick();
    check("inflight_still", {31'd0, dv_b3}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("midfill_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_fill("fill2");
    rd_a("refill5", 4'd5, 32'd0);
    rd_a("refill3", 4'd3, 32'd0);
    rd_a("refill9", 4'd9, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
